flow_table_lookup: RTL and testbench
====================================

Name: flow_table_lookup

Overview:
Exact/wildcard flow table that serves the forwarder's lookup handshake. It sits directly downstream of the forwarder's lookup request port. A lookup latches the 116-bit key (4 ingress port + 48 src MAC + 32 src IP + 32 dst IP) and scans NENTRY masked entries in priority order, one per cycle. It returns the forwarding-port bitmap of the first hit, or a miss indication. Entries are written by the host through a simple config write port.

Parameters:
NPORT, 4, width of the forwarding-port bitmap (bit n = output port n).
NENTRY, 8, number of table entries; entry 0 has the highest priority.
AW, 3, config address width; must satisfy 2^AW >= NENTRY.
MISS_PORT, 4'b0000, bitmap returned on a miss (default means drop).

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
of_lookup_req  in  1  single-cycle lookup request
of_lookup_data  in  116  lookup key, valid while of_lookup_req=1
of_lookup_ack  out  1  single-cycle result strobe
of_lookup_err  out  1  1 = miss; valid with ack and held until the next ack
of_lookup_fwd_port  out  NPORT  result bitmap; valid with ack and held until the next ack
busy  out  1  1 while a search is in progress
cfg_wr_en  in  1  entry write strobe
cfg_addr  in  AW  entry index
cfg_valid  in  1  entry valid bit to write
cfg_key  in  116  entry key
cfg_mask  in  116  compare mask; 1 = bit compared, 0 = wildcard
cfg_port  in  NPORT  entry forwarding bitmap
stat_lookup_cnt  out  16  accepted lookups, saturating at 16'hFFFF
stat_miss_cnt  out  16  misses, saturating at 16'hFFFF
stat_drop_cnt  out  16  requests ignored while busy, saturating at 16'hFFFF

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is synchronous and active-high (sys_rst).
- Reset values:
  - ack=0, err=0, fwd_port=0, busy=0, all stat counters=0.
  - All entry valid bits=0. Key, mask and port storage need no reset.
  - FSM returns to IDLE.
- Reset mid-search: the search is aborted and no ack is issued.
- FSM states: IDLE, SEARCH.
- IDLE: on of_lookup_req=1 at edge T:
  - latch the key and set idx=0;
  - go to SEARCH;
  - stat_lookup_cnt++.
- SEARCH, one entry per cycle: in cycle T+1+i, entry i hits when valid[i]=1 and ((key ^ entry_key[i]) & entry_mask[i]) == 0.
- On the first hit at entry i, at the edge ending cycle T+1+i:
  - ack=1, err=0, fwd_port=entry_port[i];
  - FSM goes to IDLE.
  - Ack is therefore high during cycle T+2+i.
- Miss: idx=NENTRY-1 is evaluated without a hit:
  - ack=1 during cycle T+1+NENTRY, err=1, fwd_port=MISS_PORT;
  - stat_miss_cnt++;
  - FSM goes to IDLE.
- Latency: from the req sampling edge to ack high is 2 cycles minimum (hit on entry 0) and NENTRY+1 cycles maximum (miss).
- Ack is a pulse exactly 1 cycle wide. Err and fwd_port hold their values until the next ack.
- busy = (state == SEARCH).
- Requests while busy: of_lookup_req=1 while in SEARCH is ignored and stat_drop_cnt++. No ack is generated for it.
- Request in the ack cycle: the FSM is already IDLE, so the request is accepted. Back-to-back lookups are therefore possible with no dead cycle.
- Priority: the lowest index wins when multiple entries hit.
- Mask all-zero with valid=1: the entry matches every key (default rule).
- Config writes:
  - cfg_wr_en=1 writes valid/key/mask/port at cfg_addr on that edge.
  - cfg_addr >= NENTRY: the write is ignored.
  - Writes are accepted in any state. During a search, a compare in a cycle after the write edge sees the new contents. The compare in the write cycle itself sees the old contents.
- Counters saturate and never wrap. Simultaneous increments of different counters are independent.
- Scan index width is AW. The search terminates on the idx == NENTRY-1 compare, so a non-power-of-2 NENTRY never reads past the table.

Test Plan:
- Reset, then req with key K0 while the table is empty -> ack in cycle T+9 (NENTRY=8), err=1, fwd_port=4'b0000, stat_miss_cnt=1, stat_lookup_cnt=1.
- Entry 0 = {valid, key K0, mask all-ones, port 4'b0010}; req K0 at edge T -> ack high exactly in cycle T+2, err=0, fwd_port=4'b0010; ack low at T+3; fwd_port still 4'b0010.
- Entry 2 port 4'b1000 and entry 5 port 4'b0100 both match; entry 7 has mask all-zero with port 4'b1111 -> ack at T+4 with fwd_port=4'b1000. After invalidating entry 2 -> ack at T+7 with 4'b0100. After also invalidating entry 5 -> ack at T+9 with 4'b1111, err=0.
- Wildcard: entry mask covers only the src-IP bits [63:32]=32'h0A000001; two keys with differing MACs and dst IPs both hit. A key with src IP 32'h0A000002 misses.
- Req accepted at T (miss path); second req at T+3 -> ignored, stat_drop_cnt=1, only one ack. Third req in the ack cycle T+9 -> accepted, ack at T+18.
- Assert sys_rst in cycle T+3 of a search -> no ack ever appears. After reset, all entries are invalid: a lookup misses, and every stat counter reads 0 before that lookup.

Source files
------------

// File: rtl/flow_table_lookup.sv
`default_nettype none
// ============================================================================
// Module : flow_table_lookup
// Masked priority flow table, scanned one entry per cycle per lookup.
// Rev    : 1.0
// ============================================================================
module flow_table_lookup #(
   parameter int               NPORT     = 4,
   parameter int               NENTRY    = 8,
   parameter int               AW        = 3,
   parameter logic [NPORT-1:0] MISS_PORT = '0
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              of_lookup_req,
   input  logic [115:0]      of_lookup_data,
   output logic              of_lookup_ack,
   output logic              of_lookup_err,
   output logic [NPORT-1:0]  of_lookup_fwd_port,
   output logic              busy,
   input  logic              cfg_wr_en,
   input  logic [AW-1:0]     cfg_addr,
   input  logic              cfg_valid,
   input  logic [115:0]      cfg_key,
   input  logic [115:0]      cfg_mask,
   input  logic [NPORT-1:0]  cfg_port,
   output logic [15:0]       stat_lookup_cnt,
   output logic [15:0]       stat_miss_cnt,
   output logic [15:0]       stat_drop_cnt
);

   localparam int            KW       = 116;
   localparam logic [AW-1:0] LAST_IDX = AW'(NENTRY - 1);
   localparam logic [AW-1:0] IDX_ONE  = AW'(1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SEARCH = 1'b1
   } state_t;

   state_t                       state_q, state_d;
   logic [KW-1:0]                srch_key_q, srch_key_d;
   logic [AW-1:0]                idx_q, idx_d;
   logic                         ack_q, ack_d;
   logic                         err_q, err_d;
   logic [NPORT-1:0]             port_q, port_d;
   logic [15:0]                  lookup_cnt_q, lookup_cnt_d;
   logic [15:0]                  miss_cnt_q, miss_cnt_d;
   logic [15:0]                  drop_cnt_q, drop_cnt_d;

   logic [NENTRY-1:0]            hit_vec;
   logic [NENTRY-1:0][NPORT-1:0] ent_port_w;
   logic                         cur_hit;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Entry storage; only the valid bits need a reset value.
   generate
      for (genvar gi = 0; gi < NENTRY; gi++) begin : g_entry
         logic             ent_valid_q;
         logic [KW-1:0]    ent_key_q;
         logic [KW-1:0]    ent_mask_q;
         logic [NPORT-1:0] ent_port_q;
         logic             wr_sel;

         assign wr_sel = cfg_wr_en && (int'(cfg_addr) == gi);

         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               ent_valid_q <= 1'b0;
            end else if (wr_sel) begin
               ent_valid_q <= cfg_valid;
            end
         end

         always_ff @(posedge sys_clk) begin
            if (wr_sel) begin
               ent_key_q  <= cfg_key;
               ent_mask_q <= cfg_mask;
               ent_port_q <= cfg_port;
            end
         end

         assign hit_vec[gi]    = ent_valid_q &&
                                 (((srch_key_q ^ ent_key_q) & ent_mask_q) == '0);
         assign ent_port_w[gi] = ent_port_q;
      end
   endgenerate

   assign cur_hit = hit_vec[idx_q];

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         srch_key_q   <= '0;
         idx_q        <= '0;
         ack_q        <= 1'b0;
         err_q        <= 1'b0;
         port_q       <= '0;
         lookup_cnt_q <= '0;
         miss_cnt_q   <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         srch_key_q   <= srch_key_d;
         idx_q        <= idx_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         port_q       <= port_d;
         lookup_cnt_q <= lookup_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      srch_key_d   = srch_key_q;
      idx_d        = idx_q;
      ack_d        = 1'b0;
      err_d        = err_q;
      port_d       = port_q;
      lookup_cnt_d = lookup_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      drop_cnt_d   = drop_cnt_q;

      case (state_q)
         IDLE: begin
            if (of_lookup_req) begin
               srch_key_d   = of_lookup_data;
               idx_d        = '0;
               state_d      = SEARCH;
               lookup_cnt_d = sat_inc(lookup_cnt_q);
            end
         end
         SEARCH: begin
            if (of_lookup_req) begin
               drop_cnt_d = sat_inc(drop_cnt_q);
            end
            // Terminating on LAST_IDX keeps the scan inside the table for any NENTRY.
            if (cur_hit) begin
               ack_d   = 1'b1;
               err_d   = 1'b0;
               port_d  = ent_port_w[idx_q];
               state_d = IDLE;
            end else if (idx_q == LAST_IDX) begin
               ack_d      = 1'b1;
               err_d      = 1'b1;
               port_d     = MISS_PORT;
               miss_cnt_d = sat_inc(miss_cnt_q);
               state_d    = IDLE;
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign of_lookup_ack      = ack_q;
   assign of_lookup_err      = err_q;
   assign of_lookup_fwd_port = port_q;
   assign busy               = (state_q == SEARCH);
   assign stat_lookup_cnt    = lookup_cnt_q;
   assign stat_miss_cnt      = miss_cnt_q;
   assign stat_drop_cnt      = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_flow_table_lookup.sv
`default_nettype none
// ============================================================================
// Module : tb_flow_table_lookup
// Directed and randomized bench with a table-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_flow_table_lookup;

   localparam int NPORT  = 4;
   localparam int NENTRY = 8;
   localparam int AW     = 3;
   localparam int KW     = 116;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              of_lookup_req = 1'b0;
   logic [KW-1:0]     of_lookup_data = '0;
   logic              of_lookup_ack;
   logic              of_lookup_err;
   logic [NPORT-1:0]  of_lookup_fwd_port;
   logic              busy;
   logic              cfg_wr_en = 1'b0;
   logic [AW-1:0]     cfg_addr = '0;
   logic              cfg_valid = 1'b0;
   logic [KW-1:0]     cfg_key = '0;
   logic [KW-1:0]     cfg_mask = '0;
   logic [NPORT-1:0]  cfg_port = '0;
   logic [15:0]       stat_lookup_cnt;
   logic [15:0]       stat_miss_cnt;
   logic [15:0]       stat_drop_cnt;

   always #5 sys_clk = ~sys_clk;

   flow_table_lookup #(
      .NPORT     (NPORT),
      .NENTRY    (NENTRY),
      .AW        (AW),
      .MISS_PORT (4'b0000)
   ) dut (
      .sys_clk            (sys_clk),
      .sys_rst            (sys_rst),
      .of_lookup_req      (of_lookup_req),
      .of_lookup_data     (of_lookup_data),
      .of_lookup_ack      (of_lookup_ack),
      .of_lookup_err      (of_lookup_err),
      .of_lookup_fwd_port (of_lookup_fwd_port),
      .busy               (busy),
      .cfg_wr_en          (cfg_wr_en),
      .cfg_addr           (cfg_addr),
      .cfg_valid          (cfg_valid),
      .cfg_key            (cfg_key),
      .cfg_mask           (cfg_mask),
      .cfg_port           (cfg_port),
      .stat_lookup_cnt    (stat_lookup_cnt),
      .stat_miss_cnt      (stat_miss_cnt),
      .stat_drop_cnt      (stat_drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // Reference model: table contents, pending search, expected registered outputs.
   bit               m_init = 0;
   bit               m_valid [NENTRY];
   logic [KW-1:0]    m_key   [NENTRY];
   logic [KW-1:0]    m_mask  [NENTRY];
   logic [NPORT-1:0] m_port  [NENTRY];
   bit               m_active;
   logic [KW-1:0]    m_skey;
   int               m_acc;
   int               m_i;
   logic             e_ack, e_err;
   logic [NPORT-1:0] e_port;
   int               e_lk, e_ms, e_dr;
   int               ec = 0;
   int               ack_count = 0;
   int               last_lat = 0;

   always @(posedge sys_clk) begin
      ec++;
      if (sys_rst) begin
         m_init   = 1;
         m_active = 0;
         e_ack = 0; e_err = 0; e_port = '0;
         e_lk = 0; e_ms = 0; e_dr = 0;
         for (int k = 0; k < NENTRY; k++) m_valid[k] = 0;
      end else begin
         e_ack = 0;
         if (m_active) begin
            // Entry compared this cycle is how far we are past the accept edge.
            m_i = ec - m_acc - 1;
            if (of_lookup_req) e_dr = sat(e_dr);
            if (m_valid[m_i] && (((m_skey ^ m_key[m_i]) & m_mask[m_i]) == '0)) begin
               e_ack = 1; e_err = 0; e_port = m_port[m_i]; m_active = 0;
            end else if (m_i == NENTRY - 1) begin
               e_ack = 1; e_err = 1; e_port = 4'b0000; e_ms = sat(e_ms); m_active = 0;
            end
         end else if (of_lookup_req) begin
            m_active = 1;
            m_skey   = of_lookup_data;
            m_acc    = ec;
            e_lk     = sat(e_lk);
         end
         if (cfg_wr_en && int'(cfg_addr) < NENTRY) begin
            m_valid[cfg_addr] = cfg_valid;
            m_key[cfg_addr]   = cfg_key;
            m_mask[cfg_addr]  = cfg_mask;
            m_port[cfg_addr]  = cfg_port;
         end
      end
      #1;
      if (m_init) begin
         chk("ack", of_lookup_ack, e_ack);
         chk("err", of_lookup_err, e_err);
         chk("fwd_port", of_lookup_fwd_port, e_port);
         chk("busy", busy, m_active);
         chk("lookup_cnt", stat_lookup_cnt, e_lk);
         chk("miss_cnt", stat_miss_cnt, e_ms);
         chk("drop_cnt", stat_drop_cnt, e_dr);
         if (of_lookup_ack === 1'b1) begin
            ack_count++;
            last_lat = ec + 1 - m_acc;
         end
      end
   end

   task automatic write_entry(input int a, input logic v, input logic [KW-1:0] k,
                              input logic [KW-1:0] m, input logic [NPORT-1:0] p);
      @(negedge sys_clk);
      cfg_wr_en = 1'b1; cfg_addr = 3'(a); cfg_valid = v;
      cfg_key = k; cfg_mask = m; cfg_port = p;
      @(negedge sys_clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic wait_ack(input int base, input string name);
      int n = 0;
      while (ack_count == base && n < 40) begin
         @(negedge sys_clk);
         n++;
      end
      chk({name, "_ack_seen"}, ack_count - base, 1);
   endtask

   task automatic lookup(input logic [KW-1:0] k, input string name, input int lat,
                         input logic err, input logic [NPORT-1:0] port);
      int base = ack_count;
      @(negedge sys_clk);
      of_lookup_req = 1'b1; of_lookup_data = k;
      @(negedge sys_clk);
      of_lookup_req = 1'b0;
      wait_ack(base, name);
      chk({name, "_lat"}, last_lat, lat);
      chk({name, "_err"}, of_lookup_err, err);
      chk({name, "_port"}, of_lookup_fwd_port, port);
   endtask

   logic [KW-1:0] pool [4];
   logic [KW-1:0] ONES, SRCIP_M;

   function automatic logic [KW-1:0] rnd_key();
      logic [KW-1:0] k = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) k[$urandom_range(0, KW-1)] ^= 1'b1;
      return k;
   endfunction

   function automatic logic [KW-1:0] rnd_mask();
      logic [KW-1:0] m;
      case ($urandom_range(0, 3))
         0:       m = ONES;
         1:       m = '0;
         2:       m = SRCIP_M;
         default: m = {4'($urandom), 16'($urandom), $urandom, $urandom, $urandom};
      endcase
      return m;
   endfunction

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [KW-1:0] K0, K1, W1, W2, WM;
      int base;

      ONES    = '1;
      SRCIP_M = {52'h0, 32'hFFFF_FFFF, 32'h0};
      K0 = {4'h1, 48'h0011_2233_4455, 32'hC0A8_0001, 32'hC0A8_0002};
      K1 = {4'h2, 48'hAABB_CCDD_EEFF, 32'h0A0A_0A0A, 32'h0808_0808};
      W1 = {4'h3, 48'h1111_1111_1111, 32'h0A00_0001, 32'h0102_0304};
      W2 = {4'h3, 48'h2222_2222_2222, 32'h0A00_0001, 32'h0506_0708};
      WM = {4'h3, 48'h1111_1111_1111, 32'h0A00_0002, 32'h0102_0304};
      pool[0] = K0; pool[1] = K1; pool[2] = W1; pool[3] = WM;

      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_ack", of_lookup_ack, 0);
      chk("rst_lookup_cnt", stat_lookup_cnt, 0);

      // Empty table: full scan then miss.
      lookup(K0, "empty_miss", 9, 1'b1, 4'b0000);
      chk("empty_miss_cnt", stat_miss_cnt, 1);
      chk("empty_lookup_cnt", stat_lookup_cnt, 1);

      // Exact hit on entry 0: minimum latency, result held after the pulse.
      write_entry(0, 1'b1, K0, ONES, 4'b0010);
      lookup(K0, "hit0", 2, 1'b0, 4'b0010);
      @(negedge sys_clk);
      chk("hit0_ack_low", of_lookup_ack, 0);
      chk("hit0_port_held", of_lookup_fwd_port, 4'b0010);

      // Priority among overlapping entries and an all-wildcard default rule.
      write_entry(2, 1'b1, K1, ONES, 4'b1000);
      write_entry(5, 1'b1, K1, ONES, 4'b0100);
      write_entry(7, 1'b1, '0, '0, 4'b1111);
      lookup(K1, "prio2", 4, 1'b0, 4'b1000);
      write_entry(2, 1'b0, K1, ONES, 4'b1000);
      lookup(K1, "prio5", 7, 1'b0, 4'b0100);
      write_entry(5, 1'b0, K1, ONES, 4'b0100);
      lookup(K1, "prio7", 9, 1'b0, 4'b1111);

      // Source-IP-only wildcard.
      write_entry(7, 1'b0, '0, '0, 4'b1111);
      write_entry(1, 1'b1, W1, SRCIP_M, 4'b0001);
      lookup(W1, "wild_a", 3, 1'b0, 4'b0001);
      lookup(W2, "wild_b", 3, 1'b0, 4'b0001);
      lookup(WM, "wild_miss", 9, 1'b1, 4'b0000);

      // Drop while busy, then a request in the ack cycle is accepted.
      base = ack_count;
      @(negedge sys_clk); of_lookup_req = 1'b1; of_lookup_data = WM;
      @(negedge sys_clk); of_lookup_req = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk); of_lookup_req = 1'b1;
      @(negedge sys_clk); of_lookup_req = 1'b0;
      wait_ack(base, "drop_first");
      chk("drop_first_lat", last_lat, 9);
      chk("drop_cnt_one", stat_drop_cnt, 1);
      of_lookup_req = 1'b1; of_lookup_data = WM;
      @(negedge sys_clk); of_lookup_req = 1'b0;
      wait_ack(base + 1, "b2b");
      chk("b2b_lat", last_lat, 9);
      repeat (4) @(negedge sys_clk);
      chk("b2b_ack_total", ack_count - base, 2);

      // Reset during a search aborts it and clears the table.
      write_entry(7, 1'b1, '0, '0, 4'b1111);
      base = ack_count;
      @(negedge sys_clk); of_lookup_req = 1'b1; of_lookup_data = K1;
      @(negedge sys_clk); of_lookup_req = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk); sys_rst = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk); sys_rst = 1'b0;
      repeat (12) @(negedge sys_clk);
      chk("rst_abort_no_ack", ack_count - base, 0);
      chk("rst2_lookup_cnt", stat_lookup_cnt, 0);
      chk("rst2_miss_cnt", stat_miss_cnt, 0);
      chk("rst2_drop_cnt", stat_drop_cnt, 0);
      lookup(K1, "rst2_miss", 9, 1'b1, 4'b0000);

      // Random traffic, config writes (including mid-search) and rare resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge sys_clk);
         of_lookup_req  = ($urandom_range(0, 3) == 0);
         of_lookup_data = rnd_key();
         cfg_wr_en      = ($urandom_range(0, 5) == 0);
         cfg_addr       = 3'($urandom_range(0, 7));
         cfg_valid      = ($urandom_range(0, 3) != 0);
         cfg_key        = rnd_key();
         cfg_mask       = rnd_mask();
         cfg_port       = 4'($urandom);
         sys_rst        = ($urandom_range(0, 599) == 0);
      end
      @(negedge sys_clk);
      of_lookup_req = 1'b0; cfg_wr_en = 1'b0; sys_rst = 1'b0;
      repeat (20) @(negedge sys_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
